// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
//   Shared types and constants for the conditional-branch controller:
//   - bht_ctr_e        : 2-bit saturating counter encoding
//   - COND_*           : branch_cond encodings evaluated against alu_out
//   - PC_INC           : fall-through PC increment
//   - inflight_entry_t : one unresolved prediction, sized for the widest
//                        supported configuration (WordSize <= WORD_MAX,
//                        $clog2(BhtEntries) <= IDX_MAX); unused upper bits
//                        are zero and are pruned in synthesis.
//   - ctr_update()     : saturating counter step
// ----------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bht_ctr_e;

    localparam logic [1:0] COND_EQZ  = 2'b00;  // taken when alu_out == 0
    localparam logic [1:0] COND_NEZ  = 2'b01;  // taken when alu_out != 0
    localparam logic [1:0] COND_ODD  = 2'b10;  // taken when alu_out[0] == 1
    localparam logic [1:0] COND_EVEN = 2'b11;  // taken when alu_out[0] == 0

    localparam int unsigned PC_INC   = 4;
    localparam int unsigned WORD_MAX = 64;
    localparam int unsigned IDX_MAX  = 16;

    typedef struct packed {
        logic [WORD_MAX-1:0] pc;
        logic [WORD_MAX-1:0] target;
        logic                pred_taken;
        logic [IDX_MAX-1:0]  idx;
    } inflight_entry_t;

    // Saturating step: never wraps past STRONG_NT or STRONG_T.
    function automatic bht_ctr_e ctr_update(input bht_ctr_e ctr, input logic taken);
        if (taken) begin
            return (ctr == STRONG_T)  ? STRONG_T  : bht_ctr_e'(2'(ctr) + 2'd1);
        end
        return (ctr == STRONG_NT) ? STRONG_NT : bht_ctr_e'(2'(ctr) - 2'd1);
    endfunction

endpackage

// File: rtl/branch_ctrl_bht_fifo.sv
// ----------------------------------------------------------------------------
// branch_inflight_fifo
//   Ordered queue of unresolved predictions. Generic over the entry type.
//   Ports:
//     clk, rstn      : clock, asynchronous active-low reset
//     push/push_data : append at tail (ignored when full)
//     pop            : remove head (ignored when empty)
//     clear          : discard all entries; wins over push and pop
//     head           : oldest entry (undefined when empty)
//     full, empty    : occupancy flags
//     count          : occupancy, 0..Depth
//   Depth must be a power of two >= 2 so pointers wrap naturally.
// ----------------------------------------------------------------------------
module branch_inflight_fifo #(
    parameter type         entry_t = logic,
    parameter int unsigned Depth   = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     clear,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    entry_t          mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left without reset; only the pointers
    // and count decide which slots hold live data.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_ctrl_bht.sv
// ----------------------------------------------------------------------------
// branch_ctrl_bht
//   Conditional-branch controller with a table of 2-bit saturating counters.
//   Predicts at fetch, queues in-flight predictions, resolves the oldest one
//   at execute and raises a one-cycle flush with the corrected next PC on a
//   mispredict.
//   Ports:
//     clk, rstn                      : clock, asynchronous active-low reset
//     pred_valid/pred_pc/pred_target : branch presented by fetch
//     pred_ready                     : queue not full (accept = valid && ready)
//     pred_taken                     : combinational prediction (counter MSB)
//     res_valid/branch_cond/alu_out  : resolution of the oldest branch
//     flush, npc_corr                : registered mispredict pulse + new PC
//     res_err                        : registered pulse, resolve on empty queue
//     inflight_cnt                   : queue occupancy
//   Optional: define BRANCH_GSHARE_EN to XOR a global taken-history register
//   into the table index.
//   Limits: WordSize <= 64, BhtEntries <= 65536 (entry struct width).
// ----------------------------------------------------------------------------
module branch_ctrl_bht
    import branch_pkg::*;
#(
    parameter int unsigned WordSize      = 32,
    parameter int unsigned BhtEntries    = 64,
    parameter int unsigned InflightDepth = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             pred_valid,
    input  logic [WordSize-1:0]              pred_pc,
    input  logic [WordSize-1:0]              pred_target,
    output logic                             pred_ready,
    output logic                             pred_taken,
    input  logic                             res_valid,
    input  logic [1:0]                       branch_cond,
    input  logic [WordSize-1:0]              alu_out,
    output logic                             flush,
    output logic [WordSize-1:0]              npc_corr,
    output logic                             res_err,
    output logic [$clog2(InflightDepth):0]   inflight_cnt
);

    localparam int unsigned IdxW = $clog2(BhtEntries);

    bht_ctr_e            bht [BhtEntries];
    logic [IdxW-1:0]     pc_idx;
    logic [IdxW-1:0]     pred_idx;
    logic                pred_accept;
    inflight_entry_t     push_entry;
    inflight_entry_t     head;
    logic                q_full;
    logic                q_empty;
    logic [IdxW-1:0]     head_idx;
    logic [WordSize-1:0] head_pc;
    logic [WordSize-1:0] head_target;
    logic                act_taken;
    logic                resolve_hit;
    logic                mispredict;
    logic [WordSize-1:0] npc_next;
    logic                unused_head;

    // PC bits [1:0] are always zero for aligned branches and are skipped.
    assign pc_idx = pred_pc[IdxW+1:2];

`ifdef BRANCH_GSHARE_EN
    logic [IdxW-1:0] ghr;

    assign pred_idx = pc_idx ^ ghr;

    // A mispredict restarts history from the one outcome that is known good.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            ghr <= '0;
        else if (mispredict)  ghr <= IdxW'(act_taken);
        else if (resolve_hit) ghr <= (ghr << 1) | IdxW'(act_taken);
    end
`else
    assign pred_idx = pc_idx;
`endif

    // Reads the table as it stands before this edge's update (no bypass).
    assign pred_taken  = (bht[pred_idx] == WEAK_T) || (bht[pred_idx] == STRONG_T);
    assign pred_ready  = !q_full;
    assign pred_accept = pred_valid && pred_ready;

    assign head_idx    = head.idx[IdxW-1:0];
    assign head_pc     = head.pc[WordSize-1:0];
    assign head_target = head.target[WordSize-1:0];
    assign unused_head = ^head;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        push_entry            = '0;
        push_entry.pc         = WORD_MAX'(pred_pc);
        push_entry.target     = WORD_MAX'(pred_target);
        push_entry.pred_taken = pred_taken;
        push_entry.idx        = IDX_MAX'(pred_idx);

        act_taken = 1'b0;
        case (branch_cond)
            COND_EQZ:  act_taken = (alu_out == '0);
            COND_NEZ:  act_taken = (alu_out != '0);
            COND_ODD:  act_taken = alu_out[0];
            COND_EVEN: act_taken = !alu_out[0];
            default:   act_taken = 1'b0;
        endcase
    end

    assign resolve_hit = res_valid && !q_empty;
    assign mispredict  = resolve_hit && (act_taken != head.pred_taken);
    assign npc_next    = act_taken ? head_target : head_pc + WordSize'(PC_INC);

    // A mispredict squashes every younger entry, including one arriving now.
    branch_inflight_fifo #(
        .entry_t (inflight_entry_t),
        .Depth   (InflightDepth)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (pred_accept && !mispredict),
        .push_data (push_entry),
        .pop       (resolve_hit && !mispredict),
        .clear     (mispredict),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (inflight_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(BhtEntries); i++) bht[i] <= WEAK_NT;
        end else if (resolve_hit) begin
            bht[head_idx] <= ctr_update(bht[head_idx], act_taken);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flush    <= 1'b0;
            npc_corr <= '0;
            res_err  <= 1'b0;
        end else begin
            flush   <= mispredict;
            res_err <= res_valid && q_empty;
            if (mispredict) npc_corr <= npc_next;
        end
    end

endmodule

// File: tb/tb_branch_ctrl_bht.sv
module tb_branch_ctrl_bht;

    localparam int W = 32;
    localparam int N = 64;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         pred_valid;
    logic [W-1:0] pred_pc;
    logic [W-1:0] pred_target;
    logic         pred_ready;
    logic         pred_taken;
    logic         res_valid;
    logic [1:0]   branch_cond;
    logic [W-1:0] alu_out;
    logic         flush;
    logic [W-1:0] npc_corr;
    logic         res_err;
    logic [2:0]   inflight_cnt;

    always #5 clk = ~clk;

    branch_ctrl_bht #(.WordSize(W), .BhtEntries(N), .InflightDepth(D)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pred_valid   (pred_valid),
        .pred_pc      (pred_pc),
        .pred_target  (pred_target),
        .pred_ready   (pred_ready),
        .pred_taken   (pred_taken),
        .res_valid    (res_valid),
        .branch_cond  (branch_cond),
        .alu_out      (alu_out),
        .flush        (flush),
        .npc_corr     (npc_corr),
        .res_err      (res_err),
        .inflight_cnt (inflight_cnt)
    );

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] tgt;
        logic         pt;
        int           idx;
    } ent_t;

    typedef struct {
        logic         flush;
        logic [W-1:0] npc;
        logic         err;
    } exp_t;

    ent_t       mq[$];
    exp_t       sb[$];
    logic [1:0] mbht [N];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic int idx_of(input logic [W-1:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic logic eval_cond(input logic [1:0] c, input logic [W-1:0] a);
        case (c)
            2'd0:    return a == 0;
            2'd1:    return a != 0;
            2'd2:    return a[0];
            default: return !a[0];
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        foreach (mbht[i]) mbht[i] = 2'b01;
    endtask

    // One clock of stimulus: checks combinational outputs before the edge,
    // advances the model, queues the expected registered outputs and checks
    // them after the edge.
    task automatic step(input logic pv, input logic [W-1:0] pc, input logic [W-1:0] tgt,
                        input logic rv, input logic [1:0] c, input logic [W-1:0] alu);
        logic e_pt, e_rdy, acc, act, mis;
        int   e_cnt;
        ent_t h, ne;
        exp_t e, got;
        pred_valid = pv; pred_pc = pc; pred_target = tgt;
        res_valid = rv; branch_cond = c; alu_out = alu;
        #1;
        e_pt  = mbht[idx_of(pc)][1];
        e_rdy = (mq.size() < D);
        e_cnt = mq.size();
        n_vec++;
        if (pred_taken !== e_pt) begin
            n_err++; $display("FAIL pred_taken pc=%h: got %b want %b", pc, pred_taken, e_pt);
        end
        n_vec++;
        if (pred_ready !== e_rdy) begin
            n_err++; $display("FAIL pred_ready: got %b want %b", pred_ready, e_rdy);
        end
        n_vec++;
        if (inflight_cnt !== 3'(e_cnt)) begin
            n_err++; $display("FAIL inflight_cnt: got %0d want %0d", inflight_cnt, e_cnt);
        end
        acc = pv && e_rdy;
        ne.pc = pc; ne.tgt = tgt; ne.pt = e_pt; ne.idx = idx_of(pc);
        e.flush = 1'b0; e.npc = '0; e.err = 1'b0;
        mis = 1'b0;
        if (rv && mq.size() > 0) begin
            h   = mq.pop_front();
            act = eval_cond(c, alu);
            if (act && mbht[h.idx] != 2'b11)       mbht[h.idx] = mbht[h.idx] + 2'b01;
            else if (!act && mbht[h.idx] != 2'b00) mbht[h.idx] = mbht[h.idx] - 2'b01;
            if (act != h.pt) begin
                mis = 1'b1;
                mq.delete();
                e.flush = 1'b1;
                e.npc   = act ? h.tgt : h.pc + 32'd4;
            end
        end else if (rv) begin
            e.err = 1'b1;
        end
        if (acc && !mis) mq.push_back(ne);
        sb.push_back(e);
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        got = sb.pop_front();
        n_vec++;
        if (flush !== got.flush) begin
            n_err++; $display("FAIL flush: got %b want %b", flush, got.flush);
        end
        n_vec++;
        if (res_err !== got.err) begin
            n_err++; $display("FAIL res_err: got %b want %b", res_err, got.err);
        end
        if (got.flush) begin
            n_vec++;
            if (npc_corr !== got.npc) begin
                n_err++; $display("FAIL npc_corr: got %h want %h", npc_corr, got.npc);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_target = '0;
        res_valid = 1'b0; branch_cond = '0; alu_out = '0;
        model_reset();
        #12;
        n_vec++;
        if (flush !== 1'b0)      begin n_err++; $display("FAIL reset flush: got %b want 0", flush); end
        n_vec++;
        if (npc_corr !== '0)     begin n_err++; $display("FAIL reset npc_corr: got %h want 0", npc_corr); end
        n_vec++;
        if (res_err !== 1'b0)    begin n_err++; $display("FAIL reset res_err: got %b want 0", res_err); end
        n_vec++;
        if (inflight_cnt !== '0) begin n_err++; $display("FAIL reset inflight_cnt: got %0d want 0", inflight_cnt); end
        rstn = 1'b1;
        #1;
        n_vec++;
        if (pred_ready !== 1'b1) begin n_err++; $display("FAIL reset pred_ready: got %b want 1", pred_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_mispredict();
        step(1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 32'h0);
        step(1'b0, 32'h100, 32'h0, 1'b1, 2'd0, 32'h0);
        n_vec++;
        if (npc_corr !== 32'h200) begin n_err++; $display("FAIL basic npc_corr: got %h want 200", npc_corr); end
    endtask

    task automatic test_saturate();
        // Four taken resolves with different condition codes, then one not-taken.
        logic [1:0]   cs [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [W-1:0] as [4] = '{32'h0, 32'h5, 32'h3, 32'h2};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 32'h0);
            step(1'b0, 32'h100, 32'h0, 1'b1, cs[i], as[i]);
        end
        n_vec++;
        if (flush !== 1'b0) begin n_err++; $display("FAIL saturate flush: got %b want 0", flush); end
        step(1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 32'h0);
        step(1'b0, 32'h100, 32'h0, 1'b1, 2'd1, 32'h0);
        step(1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 32'h0);
        step(1'b0, 32'h100, 32'h0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) step(1'b1, 32'h1000 + 32'(4 * i), 32'h1800, 1'b0, 2'd0, 32'h0);
        #1;
        n_vec++;
        if (pred_ready !== 1'b0)   begin n_err++; $display("FAIL full pred_ready: got %b want 0", pred_ready); end
        n_vec++;
        if (inflight_cnt !== 3'd4) begin n_err++; $display("FAIL full inflight_cnt: got %0d want 4", inflight_cnt); end
        step(1'b1, 32'h1020, 32'h1800, 1'b0, 2'd0, 32'h0);
        step(1'b1, 32'h1024, 32'h1800, 1'b1, 2'd1, 32'h0);
        step(1'b1, 32'h1028, 32'h1800, 1'b1, 2'd1, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 2'd1, 32'h0);
    endtask

    task automatic test_mispredict_flush();
        step(1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 32'h0);
        step(1'b1, 32'h2014, 32'h2800, 1'b0, 2'd0, 32'h0);
        step(1'b1, 32'h2018, 32'h2800, 1'b0, 2'd0, 32'h0);
        step(1'b1, 32'h201C, 32'h2800, 1'b1, 2'd1, 32'h0);
        n_vec++;
        if (inflight_cnt !== 3'd0) begin n_err++; $display("FAIL misp inflight_cnt: got %0d want 0", inflight_cnt); end
        n_vec++;
        if (npc_corr !== 32'h104)  begin n_err++; $display("FAIL misp npc_corr: got %h want 104", npc_corr); end
        step(1'b1, 32'h2020, 32'h2800, 1'b0, 2'd0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 2'd1, 32'h0);
    endtask

    task automatic test_empty_resolve();
        step(1'b0, 32'h100, 32'h0, 1'b1, 2'd0, 32'h0);
        n_vec++;
        if (res_err !== 1'b1) begin n_err++; $display("FAIL empty res_err: got %b want 1", res_err); end
        step(1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 2'd3, 32'h1);
    endtask

    task automatic test_wrap();
        step(1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 2'd0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 32'h0);
        step(1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 2'd0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h2);
        n_vec++;
        if (npc_corr !== 32'h0) begin n_err++; $display("FAIL wrap npc_corr: got %h want 0", npc_corr); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 32'h3000 + 32'(4 * $urandom_range(0, 7)),
                 32'h4000 + 32'(4 * i), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] a;
        step(1'b1, 32'h2100, 32'h2200, 1'b0, 2'd0, 32'h0);
        step(1'b1, 32'h2104, 32'h2200, 1'b0, 2'd0, 32'h0);
        a = mq[0].pt ? 32'h1 : 32'h0;
        step(1'b1, 32'h2108, 32'h2200, 1'b1, 2'd0, a);
        step(1'b1, 32'h210C, 32'h2200, 1'b0, 2'd0, 32'h0);
        #1;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (flush !== 1'b0)      begin n_err++; $display("FAIL midreset flush: got %b want 0", flush); end
        n_vec++;
        if (inflight_cnt !== '0) begin n_err++; $display("FAIL midreset inflight_cnt: got %0d want 0", inflight_cnt); end
        model_reset();
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic_mispredict();
        test_saturate();
        test_full();
        test_mispredict_flush();
        test_empty_resolve();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
